// File: rtl/pipeline_mem_arbiter_pkg.sv
// armleg_mem_pkg: shared types and constants for the IF/MEM memory arbiter.
//   state_t   - arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   owner_t   - which pipeline stage owns the outstanding access
//   DEFAULT_* - default parameter values
//   fetch_addr() - maps a fetch byte address to its 64-bit memory word
package armleg_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEFAULT_MEM_LATENCY = 2;
  localparam int DEFAULT_STARVE_MAX  = 4;

  // Instructions are 32 bits in a 64-bit memory: fetch the whole doubleword
  // and select the half later with address bit 2.
  function automatic logic [63:0] fetch_addr(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// pipeline_mem_arbiter_if: bundle of the fetch port, data port, memory port
// and stage stall outputs of the arbiter.
//   slave  - arbiter side (receives requests and memRdata, drives the rest)
//   master - environment side (pipeline stages and memory model)
interface pipeline_mem_arbiter_if;
  // fetch port
  logic        ifReq;
  logic [63:0] ifAddr;
  logic        ifValid;
  logic [31:0] ifRdata;
  // data port
  logic        dReq;
  logic        dWrite;
  logic [63:0] dAddr;
  logic [63:0] dWdata;
  logic        dValid;
  logic [63:0] dRdata;
  // memory port
  logic        memReq;
  logic        memWrite;
  logic [63:0] memAddr;
  logic [63:0] memWdata;
  logic [63:0] memRdata;
  // stage stalls
  logic        stallIF;
  logic        stallMem;

  modport slave (
    input  ifReq, ifAddr, dReq, dWrite, dAddr, dWdata, memRdata,
    output ifValid, ifRdata, dValid, dRdata,
    output memReq, memWrite, memAddr, memWdata, stallIF, stallMem
  );

  modport master (
    output ifReq, ifAddr, dReq, dWrite, dAddr, dWdata, memRdata,
    input  ifValid, ifRdata, dValid, dRdata,
    input  memReq, memWrite, memAddr, memWdata, stallIF, stallMem
  );
endinterface

// File: rtl/pipeline_mem_arbiter_grant_picker.sv
// mem_grant_picker: combinational grant decision for the arbiter.
//   i_d_req, i_if_req - pending requests
//   i_starve_cnt      - consecutive data grants made while fetch waited
//   o_grant           - some request is pending
//   o_owner           - winner: data unless fetch has hit its starvation limit
module mem_grant_picker
  import armleg_mem_pkg::*;
#(
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic       i_d_req,
  input  logic       i_if_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_grant,
  output owner_t     o_owner
);

  logic w_if_starved;

  assign w_if_starved = i_if_req && (i_starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    o_grant = i_d_req | i_if_req;
    o_owner = (i_d_req && !w_if_starved) ? OWN_D : OWN_IF;
  end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: shares one fixed-latency single-ported memory between
// the IF and MEM pipeline stages, one transaction at a time.
//   CLOCK - rising-edge clock
//   RESET - synchronous active-low reset
//   bus   - fetch/data/memory ports and stage stalls (see interface)
// Sequence per access: IDLE (grant) -> ISSUE (memReq strobe) -> WAIT
// (MEM_LATENCY cycles) -> RESP (valid pulse) -> IDLE.
module pipeline_mem_arbiter
  import armleg_mem_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int STARVE_MAX  = DEFAULT_STARVE_MAX
) (
  input logic                   CLOCK,
  input logic                   RESET,
  pipeline_mem_arbiter_if.slave bus
);

  state_t      r_state, w_state_next;
  owner_t      r_owner, w_owner_next;
  logic [3:0]  r_lat_cnt, w_lat_next;
  logic [3:0]  r_starve_cnt, w_starve_next;
  logic        r_if_hi, w_if_hi_next;
  logic        r_mem_req, w_mem_req_next;
  logic        r_mem_write, w_mem_write_next;
  logic [63:0] r_mem_addr, w_mem_addr_next;
  logic [63:0] r_mem_wdata, w_mem_wdata_next;
  logic        r_if_valid, w_if_valid_next;
  logic [31:0] r_if_rdata, w_if_rdata_next;
  logic        r_d_valid, w_d_valid_next;
  logic [63:0] r_d_rdata, w_d_rdata_next;

  logic        w_grant;
  owner_t      w_grant_owner;

  mem_grant_picker #(
    .STARVE_MAX(STARVE_MAX)
  ) u_picker (
    .i_d_req     (bus.dReq),
    .i_if_req    (bus.ifReq),
    .i_starve_cnt(r_starve_cnt),
    .o_grant     (w_grant),
    .o_owner     (w_grant_owner)
  );

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_lat_next       = r_lat_cnt;
    w_starve_next    = r_starve_cnt;
    w_if_hi_next     = r_if_hi;
    w_mem_req_next   = 1'b0;
    w_mem_write_next = r_mem_write;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_valid_next  = 1'b0;
    w_if_rdata_next  = r_if_rdata;
    w_d_valid_next   = 1'b0;
    w_d_rdata_next   = r_d_rdata;

    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_next   = ISSUE;
          w_owner_next   = w_grant_owner;
          w_mem_req_next = 1'b1;
          if (w_grant_owner == OWN_D) begin
            w_mem_write_next = bus.dWrite;
            w_mem_addr_next  = bus.dAddr;
            w_mem_wdata_next = bus.dWdata;
            // Only data grants that actually made fetch wait count toward
            // starvation; an uncontended data grant restarts the count.
            if (bus.ifReq)
              w_starve_next = (r_starve_cnt == 4'(STARVE_MAX)) ? r_starve_cnt
                                                              : r_starve_cnt + 4'd1;
            else
              w_starve_next = 4'd0;
          end else begin
            w_mem_write_next = 1'b0;
            w_mem_addr_next  = fetch_addr(bus.ifAddr);
            w_mem_wdata_next = 64'd0;
            w_if_hi_next     = bus.ifAddr[2];
            w_starve_next    = 4'd0;
          end
        end
      end
      ISSUE: begin
        w_lat_next   = 4'(MEM_LATENCY - 1);
        w_state_next = WAIT;
      end
      WAIT: begin
        if (r_lat_cnt == 4'd0) begin
          w_state_next = RESP;
          if (r_owner == OWN_IF) begin
            w_if_rdata_next = r_if_hi ? bus.memRdata[63:32] : bus.memRdata[31:0];
            w_if_valid_next = 1'b1;
          end else begin
            if (!r_mem_write)
              w_d_rdata_next = bus.memRdata;
            w_d_valid_next = 1'b1;
          end
        end else begin
          w_lat_next = r_lat_cnt - 4'd1;
        end
      end
      RESP: begin
        // Requests are deliberately not sampled here; a held request is
        // picked up in the following IDLE cycle.
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_lat_cnt    <= 4'd0;
      r_starve_cnt <= 4'd0;
      r_if_hi      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 64'd0;
      r_mem_wdata  <= 64'd0;
      r_if_valid   <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_d_valid    <= 1'b0;
      r_d_rdata    <= 64'd0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_lat_cnt    <= w_lat_next;
      r_starve_cnt <= w_starve_next;
      r_if_hi      <= w_if_hi_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_if_valid   <= w_if_valid_next;
      r_if_rdata   <= w_if_rdata_next;
      r_d_valid    <= w_d_valid_next;
      r_d_rdata    <= w_d_rdata_next;
    end
  end

  assign bus.memReq   = r_mem_req;
  assign bus.memWrite = r_mem_write;
  assign bus.memAddr  = r_mem_addr;
  assign bus.memWdata = r_mem_wdata;
  assign bus.ifValid  = r_if_valid;
  assign bus.ifRdata  = r_if_rdata;
  assign bus.dValid   = r_d_valid;
  assign bus.dRdata   = r_d_rdata;
  // Stalls are combinational so a stage freezes in the same cycle it asks.
  assign bus.stallIF  = bus.ifReq & ~r_if_valid;
  assign bus.stallMem = bus.dReq & ~r_d_valid;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb_pipeline_mem_arbiter: directed bench for pipeline_mem_arbiter.
// Three instances: default parameters (table vectors, reset mid-WAIT),
// STARVE_MAX=2 (grant order) and MEM_LATENCY=1 (short access).
module tb_pipeline_mem_arbiter;

  localparam logic [63:0] G  = 64'hA5A5_A5A5_5A5A_5A5A;  // junk on memRdata
  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W  = 64'h1122_3344_5566_7788;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] I2 = 32'h8765_4321;

  logic clk;
  logic rst0, rst_s, rst_l;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_mem_arbiter_if bus0 ();
  pipeline_mem_arbiter_if bus_s ();
  pipeline_mem_arbiter_if bus_l ();

  pipeline_mem_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(4)) u_dut (
    .CLOCK(clk), .RESET(rst0), .bus(bus0)
  );
  pipeline_mem_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(2)) u_dut_s (
    .CLOCK(clk), .RESET(rst_s), .bus(bus_s)
  );
  pipeline_mem_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4)) u_dut_l (
    .CLOCK(clk), .RESET(rst_l), .bus(bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ir;
    logic [63:0] ia;
    logic        dr;
    logic        dw;
    logic [63:0] da;
    logic [63:0] dwd;
    logic [63:0] mrd;
    logic        e_mreq;
    logic        e_mwr;
    logic [63:0] e_maddr;
    logic [63:0] e_mwd;
    logic        e_iv;
    logic [31:0] e_ird;
    logic        e_dv;
    logic [63:0] e_drd;
    logic        e_sif;
    logic        e_smem;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
                     input logic [63:0] da, input logic [63:0] dwd, input logic [63:0] mrd,
                     input logic mreq, input logic mwr, input logic [63:0] maddr,
                     input logic [63:0] mwd, input logic iv, input logic [31:0] ird,
                     input logic dv, input logic [63:0] drd, input logic sif, input logic smem);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.mrd = mrd;
    v.e_mreq = mreq; v.e_mwr = mwr; v.e_maddr = maddr; v.e_mwd = mwd; v.e_iv = iv;
    v.e_ird = ird; v.e_dv = dv; v.e_drd = drd; v.e_sif = sif; v.e_smem = smem;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.ifReq = 0;  bus0.ifAddr = 0;  bus0.dReq = 0;  bus0.dWrite = 0;
    bus0.dAddr = 0;  bus0.dWdata = 0;  bus0.memRdata = G;
    bus_s.ifReq = 0; bus_s.ifAddr = 0; bus_s.dReq = 0; bus_s.dWrite = 0;
    bus_s.dAddr = 0; bus_s.dWdata = 0; bus_s.memRdata = G;
    bus_l.ifReq = 0; bus_l.ifAddr = 0; bus_l.dReq = 0; bus_l.dWrite = 0;
    bus_l.dAddr = 0; bus_l.dWdata = 0; bus_l.memRdata = G;
  endtask

  initial begin
    logic [63:0] got_a[6];
    logic [63:0] exp_a[6];
    int          n_g;
    bit          pulse_seen;

    idle_inputs();
    rst0 = 0; rst_s = 0; rst_l = 0;

    // row 0 is the reset state; then fetch-only, contention, store
    add(0, 0, 0, 0, 0, 0, G,                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 64'h4, 0, 0, 0, 0, G,                      0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 64'h4, 0, 0, 0, 0, G,                      1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 64'h4, 0, 0, 0, 0, G,                      0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 64'h4, 0, 0, 0, 0, 64'hDEADBEEF_12345678,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 64'h4, 0, 0, 0, 0, G,                      0, 0, 0, 0, 1, DB, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, G,                          0, 0, 0, 0, 0, DB, 0, 0, 0, 0);
    add(1, 64'h10, 1, 0, 64'h40, 0, G,                0, 0, 0, 0, 0, DB, 0, 0, 1, 1);
    add(1, 64'h10, 1, 0, 64'h40, 0, G,                1, 0, 64'h40, 0, 0, DB, 0, 0, 1, 1);
    add(1, 64'h10, 1, 0, 64'h40, 0, G,                0, 0, 64'h40, 0, 0, DB, 0, 0, 1, 1);
    add(1, 64'h10, 1, 0, 64'h40, 0, D1,               0, 0, 64'h40, 0, 0, DB, 0, 0, 1, 1);
    add(1, 64'h10, 1, 0, 64'h40, 0, G,                0, 0, 64'h40, 0, 0, DB, 1, D1, 1, 0);
    add(1, 64'h10, 0, 0, 0, 0, G,                     0, 0, 64'h40, 0, 0, DB, 0, D1, 1, 0);
    add(1, 64'h10, 0, 0, 0, 0, G,                     1, 0, 64'h10, 0, 0, DB, 0, D1, 1, 0);
    add(1, 64'h10, 0, 0, 0, 0, G,                     0, 0, 64'h10, 0, 0, DB, 0, D1, 1, 0);
    add(1, 64'h10, 0, 0, 0, 0, 64'hCAFEF00D_87654321, 0, 0, 64'h10, 0, 0, DB, 0, D1, 1, 0);
    add(1, 64'h10, 0, 0, 0, 0, G,                     0, 0, 64'h10, 0, 1, I2, 0, D1, 0, 0);
    add(0, 0, 0, 0, 0, 0, G,                          0, 0, 64'h10, 0, 0, I2, 0, D1, 0, 0);
    add(0, 0, 1, 1, 64'h80, W, G,                     0, 0, 64'h10, 0, 0, I2, 0, D1, 0, 1);
    add(0, 0, 1, 1, 64'h80, W, G,                     1, 1, 64'h80, W, 0, I2, 0, D1, 0, 1);
    add(0, 0, 1, 1, 64'h80, W, G,                     0, 1, 64'h80, W, 0, I2, 0, D1, 0, 1);
    add(0, 0, 1, 1, 64'h80, W, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h80, W, 0, I2, 0, D1, 0, 1);
    add(0, 0, 1, 1, 64'h80, W, G,                     0, 1, 64'h80, W, 0, I2, 1, D1, 0, 0);
    add(0, 0, 0, 0, 0, 0, G,                          0, 1, 64'h80, W, 0, I2, 0, D1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    rst0 = 1; rst_s = 1; rst_l = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus0.ifReq = vecs[i].ir;  bus0.ifAddr = vecs[i].ia; bus0.dReq = vecs[i].dr;
      bus0.dWrite = vecs[i].dw; bus0.dAddr = vecs[i].da;  bus0.dWdata = vecs[i].dwd;
      bus0.memRdata = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d.memReq", i),   bus0.memReq,   vecs[i].e_mreq);
      chk($sformatf("v%0d.memWrite", i), bus0.memWrite, vecs[i].e_mwr);
      chk($sformatf("v%0d.memAddr", i),  bus0.memAddr,  vecs[i].e_maddr);
      chk($sformatf("v%0d.memWdata", i), bus0.memWdata, vecs[i].e_mwd);
      chk($sformatf("v%0d.ifValid", i),  bus0.ifValid,  vecs[i].e_iv);
      chk($sformatf("v%0d.ifRdata", i),  bus0.ifRdata,  vecs[i].e_ird);
      chk($sformatf("v%0d.dValid", i),   bus0.dValid,   vecs[i].e_dv);
      chk($sformatf("v%0d.dRdata", i),   bus0.dRdata,   vecs[i].e_drd);
      chk($sformatf("v%0d.stallIF", i),  bus0.stallIF,  vecs[i].e_sif);
      chk($sformatf("v%0d.stallMem", i), bus0.stallMem, vecs[i].e_smem);
      $display("vec %0d: memReq=%b ifValid=%b dValid=%b errors=%0d",
               i, bus0.memReq, bus0.ifValid, bus0.dValid, n_errors);
      next_cycle();
    end

    // Reset while a load is in WAIT: outputs clear, late data ignored.
    bus0.dReq = 1; bus0.dWrite = 0; bus0.dAddr = 64'h48;
    next_cycle();
    @(negedge clk);
    chk("rst.issue", bus0.memReq, 1'b1);
    next_cycle();
    rst0 = 0;
    next_cycle();
    rst0 = 1; bus0.dReq = 0; bus0.memRdata = 64'h7777_6666_5555_4444;
    @(negedge clk);
    chk("rst.memReq",   bus0.memReq,   1'b0);
    chk("rst.memWrite", bus0.memWrite, 1'b0);
    chk("rst.memAddr",  bus0.memAddr,  64'd0);
    chk("rst.memWdata", bus0.memWdata, 64'd0);
    chk("rst.ifValid",  bus0.ifValid,  1'b0);
    chk("rst.ifRdata",  bus0.ifRdata,  32'd0);
    chk("rst.dValid",   bus0.dValid,   1'b0);
    chk("rst.dRdata",   bus0.dRdata,   64'd0);
    $display("reset mid-WAIT: outputs sampled, errors=%0d", n_errors);
    next_cycle();
    bus0.memRdata = G;
    pulse_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus0.dValid || bus0.ifValid || bus0.memReq) pulse_seen = 1;
      next_cycle();
    end
    chk("rst.no_pulse", pulse_seen, 1'b0);
    bus0.ifReq = 1; bus0.ifAddr = 64'h30;
    @(negedge clk);
    chk("rst.idle_wait", bus0.memReq, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rst.idle_issue", bus0.memReq, 1'b1);
    chk("rst.idle_addr",  bus0.memAddr, 64'h30);
    next_cycle();
    bus0.ifReq = 0;

    // Starvation guard, STARVE_MAX=2: both requesters held continuously.
    exp_a = '{64'h208, 64'h208, 64'h100, 64'h208, 64'h208, 64'h100};
    got_a = '{default: 64'd0};
    bus_s.ifReq = 1; bus_s.ifAddr = 64'h100;
    bus_s.dReq = 1; bus_s.dWrite = 0; bus_s.dAddr = 64'h208;
    n_g = 0;
    for (int c = 0; c < 100 && n_g < 6; c++) begin
      @(negedge clk);
      if (bus_s.memReq) begin
        got_a[n_g] = bus_s.memAddr;
        $display("starve grant %0d: memAddr=0x%0h", n_g, bus_s.memAddr);
        n_g++;
      end
      next_cycle();
    end
    chk("starve.count", 64'(n_g), 64'd6);
    for (int i = 0; i < n_g; i++)
      chk($sformatf("starve.grant%0d", i), got_a[i], exp_a[i]);
    bus_s.ifReq = 0; bus_s.dReq = 0;

    // MEM_LATENCY=1: load, then a fetch accepted right after RESP.
    bus_l.dReq = 1; bus_l.dWrite = 0; bus_l.dAddr = 64'h18;
    @(negedge clk);
    chk("lat1.c0.memReq", bus_l.memReq, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("lat1.c1.memReq", bus_l.memReq, 1'b1);
    chk("lat1.c1.memAddr", bus_l.memAddr, 64'h18);
    next_cycle();
    bus_l.memRdata = 64'h0F0E_0D0C_0B0A_0908;
    @(negedge clk);
    chk("lat1.c2.dValid", bus_l.dValid, 1'b0);
    next_cycle();
    bus_l.memRdata = G;
    @(negedge clk);
    chk("lat1.c3.dValid", bus_l.dValid, 1'b1);
    chk("lat1.c3.dRdata", bus_l.dRdata, 64'h0F0E_0D0C_0B0A_0908);
    next_cycle();
    bus_l.dReq = 0; bus_l.ifReq = 1; bus_l.ifAddr = 64'h24;
    @(negedge clk);
    chk("lat1.c4.dValid", bus_l.dValid, 1'b0);
    chk("lat1.c4.memReq", bus_l.memReq, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("lat1.c5.memReq", bus_l.memReq, 1'b1);
    chk("lat1.c5.memAddr", bus_l.memAddr, 64'h20);
    next_cycle();
    bus_l.memRdata = 64'h1111_2222_3333_4444;
    next_cycle();
    bus_l.memRdata = G;
    @(negedge clk);
    chk("lat1.c7.ifValid", bus_l.ifValid, 1'b1);
    chk("lat1.c7.ifRdata", bus_l.ifRdata, 32'h1111_2222);
    $display("latency-1 sequence done, errors=%0d", n_errors);
    next_cycle();
    bus_l.ifReq = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
